// File: rtl/denise_pkg.sv
// Shared Denise definitions: colour register base, FSM state encoding and
// the 24-bit RGB record built from the high/low nibble palette banks.
package denise_pkg;

    localparam logic [8:0] COLORBASE = 9'h180;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } ct_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    function automatic rgb24_t expand12(input logic [11:0] hi, input logic [11:0] lo);
        rgb24_t v;
        v.r = {hi[11:8], lo[11:8]};
        v.g = {hi[7:4],  lo[7:4]};
        v.b = {hi[3:0],  lo[3:0]};
        return v;
    endfunction

endpackage

// File: rtl/denise_colortable_ram.sv
// Single-write, single-read synchronous RAM; the read returns the pre-write
// contents when both ports address the same entry on the same edge.
module denise_colortable_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 12,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/denise_colortable_aga.sv
// AGA colour table: 24-bit palette held as high/low nibble banks, bus writes
// with bank select and LOCT, XOR-masked lookup with EHB, and a clear sweep.
module denise_colortable_aga #(
    parameter logic [8:0]  COLORBASE = denise_pkg::COLORBASE,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BANK_W    = (DEPTH > 32) ? $clog2(DEPTH / 32) : 1,
    parameter int unsigned SEL_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk7_en,
    input  logic [8:1]        reg_address_in,
    input  logic [11:0]       data_in,
    input  logic [BANK_W-1:0] bank,
    input  logic              loct,
    input  logic [SEL_W-1:0]  select,
    input  logic [SEL_W-1:0]  xor_mask,
    input  logic              ehb,
    input  logic              a1k,
    output logic [23:0]       rgb,
    output logic              init_done
);

    import denise_pkg::*;

    ct_state_t        r_state;
    logic [SEL_W-1:0] r_cnt;
    logic             r_init_done;
    logic             r_ehb;
    logic [23:0]      r_rgb;

    logic             w_init;
    logic             w_bus_hit;
    logic [SEL_W-1:0] w_bus_idx;
    logic [SEL_W-1:0] w_waddr;
    logic [11:0]      w_wdata;
    logic             w_we_hi;
    logic             w_we_lo;
    logic [SEL_W-1:0] w_eff;
    logic [SEL_W-1:0] w_raddr;
    logic             w_ehb;
    logic [11:0]      w_hi_q;
    logic [11:0]      w_lo_q;
    rgb24_t           w_pix;
    rgb24_t           w_shaded;

    // With a single 32-entry bank there is no bank field and no EHB half.
    generate
        if (DEPTH > 32) begin : g_banked
            always_comb begin
                w_bus_idx = {bank, reg_address_in[5:1]};
                w_eff     = select ^ xor_mask;
                w_ehb     = ehb & ~a1k & w_eff[5];
                w_raddr   = w_eff;
                if (w_ehb) begin
                    w_raddr[SEL_W-1:5] = '0;
                end
            end
        end else begin : g_flat
            logic w_bank_unused;
            assign w_bank_unused = &{1'b0, bank, ehb, a1k};
            always_comb begin
                w_bus_idx = reg_address_in[5:1];
                w_eff     = select ^ xor_mask;
                w_ehb     = 1'b0;
                w_raddr   = w_eff;
            end
        end
    endgenerate

    always_comb begin
        w_init    = (r_state == ST_INIT);
        w_bus_hit = clk7_en && (reg_address_in[8:6] == COLORBASE[8:6]) && (r_state == ST_RUN);
        w_waddr   = w_init ? r_cnt : w_bus_idx;
        w_wdata   = w_init ? '0 : data_in;
        w_we_lo   = w_init | w_bus_hit;
        w_we_hi   = w_init | (w_bus_hit & ~loct);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= (r_state == ST_RUN);
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SEL_W'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    denise_colortable_ram #(
        .DEPTH (DEPTH),
        .WIDTH (12),
        .AW    (SEL_W)
    ) u_ram_hi (
        .i_clk   (clk),
        .i_we    (w_we_hi),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_hi_q)
    );

    denise_colortable_ram #(
        .DEPTH (DEPTH),
        .WIDTH (12),
        .AW    (SEL_W)
    ) u_ram_lo (
        .i_clk   (clk),
        .i_we    (w_we_lo),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_lo_q)
    );

    // Stage 1 flag travels alongside the registered RAM read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ehb <= 1'b0;
        end else begin
            r_ehb <= w_ehb;
        end
    end

    always_comb begin
        w_pix    = expand12(w_hi_q, w_lo_q);
        w_shaded = w_pix;
        if (r_ehb) begin
            w_shaded.r = {1'b0, w_pix.r[7:1]};
            w_shaded.g = {1'b0, w_pix.g[7:1]};
            w_shaded.b = {1'b0, w_pix.b[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !r_init_done) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_shaded;
        end
    end

    assign rgb       = r_rgb;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_denise_colortable_aga.sv
// Bench for denise_colortable_aga: clear sweep, bus writes, LOCT, bank/XOR
// lookup, EHB, read-during-write and mid-sweep reset.
module tb_denise_colortable_aga;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en;
    logic [8:1]  reg_address_in;
    logic [11:0] data_in;
    logic [2:0]  bank;
    logic        loct;
    logic [7:0]  select;
    logic [7:0]  xor_mask;
    logic        ehb;
    logic        a1k;
    logic [23:0] rgb;
    logic        init_done;

    always #5 clk = ~clk;

    denise_colortable_aga #(
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk7_en        (clk7_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .bank           (bank),
        .loct           (loct),
        .select         (select),
        .xor_mask       (xor_mask),
        .ehb            (ehb),
        .a1k            (a1k),
        .rgb            (rgb),
        .init_done      (init_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [23:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          wr;
        logic [8:0]  addr;
        logic [11:0] data;
        logic [2:0]  bnk;
        bit          lc;
        logic [7:0]  sel;
        logic [7:0]  xm;
        bit          e;
        bit          a;
        logic [23:0] exp;
        string       name;
    } vec_t;
    vec_t vt[12];

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            if (x.due != cyc) begin
                errors++;
                $display("FAIL %s: result missed at cycle %0d (due %0d)", x.name, cyc, x.due);
            end else if (rgb !== x.exp) begin
                errors++;
                $display("FAIL %s: rgb=%06h expected %06h", x.name, rgb, x.exp);
            end
        end
    end

    task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", nm, got, exp);
        end
    endtask

    task automatic bus_write(input logic [8:0] a, input logic [11:0] d,
                             input logic [2:0] b, input logic lc);
        logic [8:0] av;
        av = a;
        @(posedge clk); #1;
        reg_address_in = av[8:1];
        data_in        = d;
        bank           = b;
        loct           = lc;
        clk7_en        = 1'b1;
    endtask

    task automatic lookup(input logic [7:0] s, input logic [7:0] xm, input logic e,
                          input logic a, input logic [23:0] x, input string nm);
        exp_t item;
        @(posedge clk); #1;
        clk7_en  = 1'b0;
        select   = s;
        xor_mask = xm;
        ehb      = e;
        a1k      = a;
        item.due  = cyc + 2;
        item.exp  = x;
        item.name = nm;
        sb.push_back(item);
    endtask

    task automatic sweep_check(input string tag);
        for (int e = 1; e <= DEPTH + 1; e++) begin
            @(negedge clk);
            if (e == 1 || e == DEPTH)
                chk({tag, "_init_done_low"}, {23'd0, init_done}, 24'd0);
            if (e == DEPTH + 1)
                chk({tag, "_init_done_high"}, {23'd0, init_done}, 24'd1);
            if (e == 5 || e == 128 || e == DEPTH)
                chk({tag, "_rgb_zero_in_init"}, rgb, 24'd0);
            select   = 8'($urandom);
            xor_mask = 8'($urandom);
            if (e == 49) begin
                reg_address_in = 8'hC2;
                data_in        = 12'hFFF;
                bank           = 3'd0;
                loct           = 1'b0;
                clk7_en        = 1'b1;
            end else begin
                clk7_en = 1'b0;
            end
        end
        xor_mask = '0;
    endtask

    initial begin
        reset_n        = 1'b0;
        clk7_en        = 1'b0;
        reg_address_in = '0;
        data_in        = '0;
        bank           = '0;
        loct           = 1'b0;
        select         = '0;
        xor_mask       = '0;
        ehb            = 1'b0;
        a1k            = 1'b0;

        vt[0]  = '{1'b1, 9'h180, 12'hF80, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 24'hFF8800, "ocs_write"};
        vt[1]  = '{1'b1, 9'h180, 12'h123, 3'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 24'hF18203, "loct_write"};
        vt[2]  = '{1'b1, 9'h182, 12'hABC, 3'd3, 1'b0, 8'h61, 8'h00, 1'b0, 1'b0, 24'hAABBCC, "bank3_write"};
        vt[3]  = '{1'b0, 9'h000, 12'h000, 3'd0, 1'b0, 8'h60, 8'h01, 1'b0, 1'b0, 24'hAABBCC, "xor_mask"};
        vt[4]  = '{1'b1, 9'h182, 12'hFFF, 3'd0, 1'b0, 8'h21, 8'h00, 1'b1, 1'b0, 24'h7F7F7F, "ehb_half"};
        vt[5]  = '{1'b1, 9'h182, 12'h5A3, 3'd1, 1'b0, 8'h21, 8'h00, 1'b1, 1'b1, 24'h55AA33, "a1k_no_ehb"};
        vt[6]  = '{1'b0, 9'h000, 12'h000, 3'd0, 1'b0, 8'h21, 8'h00, 1'b0, 1'b0, 24'h55AA33, "ehb_off"};
        vt[7]  = '{1'b1, 9'h100, 12'hFFF, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 24'hF18203, "addr_miss"};
        vt[8]  = '{1'b1, 9'h1BE, 12'h0F0, 3'd7, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 24'h00FF00, "last_entry"};
        vt[9]  = '{1'b0, 9'h000, 12'h000, 3'd0, 1'b0, 8'h3F, 8'hC0, 1'b0, 1'b0, 24'h00FF00, "xor_last"};
        vt[10] = '{1'b0, 9'h000, 12'h000, 3'd0, 1'b0, 8'hE0, 8'h01, 1'b1, 1'b0, 24'h7F7F7F, "ehb_high_bits"};
        vt[11] = '{1'b0, 9'h000, 12'h000, 3'd0, 1'b0, 8'h61, 8'h00, 1'b1, 1'b0, 24'h7F7F7F, "ehb_bank3"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        sweep_check("sweep");

        lookup(8'h02, 8'h00, 1'b0, 1'b0, 24'h000000, "init_write_dropped");

        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].data, vt[i].bnk, vt[i].lc);
            lookup(vt[i].sel, vt[i].xm, vt[i].e, vt[i].a, vt[i].exp, vt[i].name);
        end

        // Read-during-write: same-edge lookup sees the old value.
        bus_write(9'h18A, 12'h111, 3'd0, 1'b0);
        lookup(8'h05, 8'h00, 1'b0, 1'b0, 24'h111111, "rdw_setup");
        begin
            exp_t item;
            @(posedge clk); #1;
            reg_address_in = 8'hC5;
            data_in        = 12'h222;
            bank           = 3'd0;
            loct           = 1'b0;
            clk7_en        = 1'b1;
            select         = 8'h05;
            item.due  = cyc + 2;
            item.exp  = 24'h111111;
            item.name = "rdw_old";
            sb.push_back(item);
        end
        lookup(8'h05, 8'h00, 1'b0, 1'b0, 24'h222222, "rdw_new");
        data_in = 12'h333;
        lookup(8'h05, 8'h00, 1'b0, 1'b0, 24'h222222, "clk7_gate");
        repeat (4) @(posedge clk);

        // Mid-sweep reset restarts the clear from entry 0.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("reset_rgb_zero", rgb, 24'd0);
        chk("reset_init_done", {23'd0, init_done}, 24'd0);
        reset_n = 1'b1;
        sweep_check("resweep");

        for (int i = 0; i < DEPTH; i++)
            lookup(8'(i), 8'h00, 1'b0, 1'b0, 24'h000000, "cleared_entry");

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
